uart_tx_scheduler: RTL and testbench

Buffers bytes written by the core to the UART transmit register and sequences them into the UART transmitter one at a time, so software no longer has to poll the UART busy flag before every write. It sits between the memory controller's UART_TX write strobe and the UART TX core. It also provides an aggregated busy status for the UART_BUSY read path, and a sticky overflow flag.

---
 rtl/uart_tx_scheduler.sv | 126 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: byte FIFO in front of the UART TX core. Accepts
// tx_send writes without stalling, feeds the UART one byte at a time
// with a start pulse, and waits for the busy handshake (or a timeout).
// Aggregated busy status and a sticky overflow flag are provided.
module uart_tx_scheduler #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                tx_wrdata,
  input  logic                       tx_send,
  input  logic                       uart_busy,
  output logic [7:0]                 uart_tx_data,
  output logic                       uart_tx_start,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       ovf_clear,
  output logic                       busy_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          push, pop, drop;

  // Only the low byte of the bus word is transmitted.
  logic unused_hi;
  assign unused_hi = ^tx_wrdata[31:8];

  assign fifo_full   = (level_q == LW'(DEPTH));
  assign fifo_empty  = (level_q == '0);
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign uart_tx_data  = data_q;
  assign uart_tx_start = (state_q == S_START);
  assign busy_status = !fifo_empty || (state_q != S_IDLE) || uart_busy;

  // A pop frees a slot in the same cycle, so a write to a full FIFO is
  // still accepted when the head is leaving.
  assign pop  = (state_q == S_IDLE) && !fifo_empty && !uart_busy;
  assign push = tx_send && (!fifo_full || pop);
  assign drop = tx_send && fifo_full && !pop;

  // FIFO bookkeeping and sticky overflow (set wins over clear).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
      data_d = mem_q[rptr_q];
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clear) ovf_d = 1'b0;
  end

  // Handshake FSM: pop, pulse start, wait for busy to rise then fall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:     if (pop) state_d = S_START;
      S_START: begin
        cnt_d   = CW'(ACK_TIMEOUT - 1);
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (uart_busy)           state_d = S_WAIT_DONE;
        else if (cnt_q == '0)    state_d = S_IDLE;   // no ack: treat as sent
        else                     cnt_d   = cnt_q - CW'(1);
      end
      default:    if (!uart_busy) state_d = S_IDLE;
    endcase
  end

  // Control state; reset discards queued bytes and any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Storage array; validity is tracked by pointers/level, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= tx_wrdata[7:0];
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple UART busy model.
module tb_uart_tx_scheduler;

  logic        clk, rst;
  logic [31:0] tx_wrdata;
  logic        tx_send, uart_busy, ovf_clear;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start, fifo_full, fifo_empty, overflow, busy_status;
  logic [3:0]  level;

  int nvec = 0, nerr = 0;
  int cyc = 0, last_pulse = -100;
  int busy_len = 3, bcnt = 0;
  logic model_en = 1'b1, hold_busy = 1'b0;
  logic [7:0] sent[$];
  int pcyc[$];

  uart_tx_scheduler #(.DEPTH(8), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .tx_wrdata(tx_wrdata), .tx_send(tx_send),
    .uart_busy(uart_busy), .uart_tx_data(uart_tx_data),
    .uart_tx_start(uart_tx_start), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .level(level), .overflow(overflow),
    .ovf_clear(ovf_clear), .busy_status(busy_status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign uart_busy = hold_busy | (bcnt > 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor plus UART model: busy rises right after a start pulse.
  always @(negedge clk) begin
    if (uart_tx_start) begin
      chk("start_while_busy", {31'd0, uart_busy}, 32'd0);
      chk("pulse_spacing", {31'd0, (cyc - last_pulse) >= 4}, 32'd1);
      last_pulse <= cyc;
      sent.push_back(uart_tx_data);
      pcyc.push_back(cyc);
    end
    if (rst)                           bcnt <= 0;
    else if (model_en && uart_tx_start) bcnt <= busy_len;
    else if (bcnt > 0)                  bcnt <= bcnt - 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] b);
    tx_wrdata = {24'h0000_01, b};
    tx_send   = 1'b1;
    step();
    tx_send   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy_status) break;
      step();
    end
    chk(tag, {31'd0, busy_status}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; tx_send = 1'b0; tx_wrdata = '0; ovf_clear = 1'b0;
    step(); step();
    // Reset values
    chk("rst_data",  {24'd0, uart_tx_data}, 32'd0);
    chk("rst_start", {31'd0, uart_tx_start}, 32'd0);
    chk("rst_full",  {31'd0, fifo_full}, 32'd0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow}, 32'd0);
    chk("rst_busy",  {31'd0, busy_status}, 32'd0);
    rst = 1'b0;
    step();

    // Single byte: pulse in cycle 2 carrying 0x41
    busy_len = 3;
    tx_wrdata = 32'h0000_0141; tx_send = 1'b1;
    step();                                   // now cycle 1
    tx_send = 1'b0;
    chk("sb_c1_level", {28'd0, level}, 32'd1);
    chk("sb_c1_busy",  {31'd0, busy_status}, 32'd1);
    chk("sb_c1_start", {31'd0, uart_tx_start}, 32'd0);
    step();                                   // cycle 2
    chk("sb_c2_start", {31'd0, uart_tx_start}, 32'd1);
    chk("sb_c2_data",  {24'd0, uart_tx_data}, 32'h41);
    chk("sb_c2_level", {28'd0, level}, 32'd0);
    step();
    chk("sb_c3_busy",  {31'd0, busy_status}, 32'd1);
    wait_idle("sb_idle", 50);
    chk("sb_count", sent.size(), 32'd1);
    chk("sb_byte",  {24'd0, sent[0]}, 32'h41);

    // Burst ordering with 20-cycle busy per byte
    sent.delete(); pcyc.delete();
    busy_len = 20;
    for (int i = 0; i < 8; i++) write(8'h10 + 8'(i));
    wait_idle("burst_idle", 400);
    chk("burst_count", sent.size(), 32'd8);
    for (int i = 0; i < 8 && i < sent.size(); i++)
      chk("burst_order", {24'd0, sent[i]}, 32'h10 + 32'(i));

    // Overflow with UART held busy
    sent.delete(); pcyc.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 9; i++) write(8'h20 + 8'(i));
    chk("ovf_level", {28'd0, level}, 32'd8);
    chk("ovf_full",  {31'd0, fifo_full}, 32'd1);
    chk("ovf_flag",  {31'd0, overflow}, 32'd1);
    // Drop and clear together: set wins
    tx_wrdata = 32'h2A; tx_send = 1'b1; ovf_clear = 1'b1;
    step();
    tx_send = 1'b0;
    chk("ovf_setprio", {31'd0, overflow}, 32'd1);
    step();
    ovf_clear = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    chk("ovf_level2",  {28'd0, level}, 32'd8);

    // Full + simultaneous pop: release busy and write in the pop cycle
    busy_len = 3;
    hold_busy = 1'b0;
    write(8'h29);
    chk("fp_level", {28'd0, level}, 32'd8);
    chk("fp_full",  {31'd0, fifo_full}, 32'd1);
    chk("fp_ovf",   {31'd0, overflow}, 32'd0);
    wait_idle("fp_idle", 300);
    chk("fp_count", sent.size(), 32'd9);
    for (int i = 0; i < 8 && i < sent.size(); i++)
      chk("fp_order", {24'd0, sent[i]}, 32'h20 + 32'(i));
    if (sent.size() == 9) chk("fp_last", {24'd0, sent[8]}, 32'h29);

    // Ack timeout: UART never raises busy; pulses every 2+ACK_TIMEOUT cycles
    sent.delete(); pcyc.delete();
    model_en = 1'b0;
    for (int i = 0; i < 3; i++) write(8'h30 + 8'(i));
    wait_idle("to_idle", 100);
    chk("to_count", sent.size(), 32'd3);
    if (sent.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("to_order", {24'd0, sent[i]}, 32'h30 + 32'(i));
      chk("to_gap1", pcyc[1] - pcyc[0], 32'd6);
      chk("to_gap2", pcyc[2] - pcyc[1], 32'd6);
    end

    // Reset mid-stream during WAIT_DONE with 3 bytes queued
    sent.delete(); pcyc.delete();
    model_en = 1'b1; busy_len = 20;
    for (int i = 0; i < 4; i++) write(8'h40 + 8'(i));
    for (int i = 0; i < 50 && sent.size() == 0; i++) step();
    chk("rm_pulse", sent.size(), 32'd1);
    step(); step(); step();
    chk("rm_level_pre", {28'd0, level}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("rm_level", {28'd0, level}, 32'd0);
    chk("rm_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rm_start", {31'd0, uart_tx_start}, 32'd0);
    chk("rm_data",  {24'd0, uart_tx_data}, 32'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) step();
    chk("rm_nopulse", sent.size(), 32'd1);
    chk("rm_busy",    {31'd0, busy_status}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
